// File: rtl/mmio_uart_tx.sv
//==============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter. It sits on the CPU
//               memory-stage bus alongside the data RAM. Byte stores to
//               TXDATA are queued in a FIFO and sent as serial frames on
//               o_Tx_1. Loads from STATUS return FIFO and transmitter state
//               one cycle later, which matches the data RAM read latency.
//
// Register map (byte addresses):
//   BASE_ADDR + 0 : TXDATA  (W)  bits [7:0] are queued for transmission
//   BASE_ADDR + 4 : STATUS  (R)  bit0 full, bit1 empty, bit2 busy,
//                                bit3 overflow (sticky), bit4 parity-enabled,
//                                bits[15:8] FIFO count
//                           (W)  writing 1 to bit3 clears overflow
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   i_Load_1        memory-stage load strobe
//   i_Store_1       memory-stage store strobe
//   i_Addr_32       memory-stage byte address
//   i_StoreData_32  store data (bits [7:0] are the byte; bit3 clears overflow)
//   o_Hit_1         combinational hit on the 8-byte register window
//   o_LoadData_32   registered STATUS read data
//   o_Tx_1          serial line, idle high
//
// Build option:
//   MMIO_UART_TX_PARITY_EN  When defined, an even-parity bit is sent between
//                           the data bits and the stop bit (8E1 framing) and
//                           STATUS bit4 reads 1. When undefined, frames are
//                           8N1 and STATUS bit4 reads 0.
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic [31:0] i_Addr_32,
  input  logic [31:0] i_StoreData_32,
  output logic        o_Hit_1,
  output logic [31:0] o_LoadData_32,
  output logic        o_Tx_1
);

  //--------------------------------------------------------------------------
  // Derived constants
  //--------------------------------------------------------------------------
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);

  // Transmit FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       PARITY_FLAG = 1'b1;
`else
  localparam logic       PARITY_FLAG = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Address decode
  //--------------------------------------------------------------------------
  logic w_is_txdata;
  logic w_is_status;

  // o_Hit_1 covers the whole 8-byte window so the top-level can steer the
  // load mux away from RAM even for unused offsets inside the window.
  assign o_Hit_1     = (i_Addr_32[31:3] == BASE_ADDR[31:3]);
  assign w_is_txdata = (i_Addr_32 == BASE_ADDR);
  assign w_is_status = (i_Addr_32 == STATUS_ADDR);

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;

  logic [2:0]        state_q,  state_d;
  logic [BAUD_W-1:0] baud_q,   baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q,  shift_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [31:0]       load_data_q, load_data_d;

  //--------------------------------------------------------------------------
  // FIFO control
  //--------------------------------------------------------------------------
  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;
  logic w_ovf_set;
  logic w_ovf_clr;

  assign w_full  = (count_q == CNT_FULL);
  assign w_empty = (count_q == '0);

  // Full is judged on the pre-edge count, so a store that lands in the same
  // cycle as a dequeue from a full FIFO is still dropped.
  assign w_enq     = i_Store_1 & w_is_txdata & ~w_full;
  assign w_ovf_set = i_Store_1 & w_is_txdata &  w_full;
  assign w_ovf_clr = i_Store_1 & w_is_status & i_StoreData_32[3];

  // The transmitter pops only from IDLE, which also guarantees non-empty.
  assign w_deq = (state_q == S_IDLE) & ~w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (w_enq) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({w_enq, w_deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set and clear are both stores on one port, so they never coincide.
    if (w_ovf_set) begin
      ovf_d = 1'b1;
    end else if (w_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Storage carries no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      fifo_mem_q[wr_ptr_q] <= i_StoreData_32[7:0];
    end
  end

  //--------------------------------------------------------------------------
  // Transmit FSM
  //--------------------------------------------------------------------------
  logic       w_bit_end;
  logic [7:0] w_head;

  assign w_bit_end = (baud_q == BAUD_LAST);
  assign w_head    = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef MMIO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          shift_d = w_head;
`ifdef MMIO_UART_TX_PARITY_EN
          // Parity is captured at load time since the shift register is
          // consumed by the time the parity bit goes out.
          parity_d = ^w_head;
`endif
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is decoded straight from the state registers, so an
  // asynchronous reset returns the line to idle-high immediately.
  always_comb begin
    o_Tx_1 = 1'b1;
    unique case (state_q)
      S_START: o_Tx_1 = 1'b0;
      S_DATA:  o_Tx_1 = shift_q[0];
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: o_Tx_1 = parity_q;
`endif
      default: o_Tx_1 = 1'b1;
    endcase
  end

  //--------------------------------------------------------------------------
  // STATUS read path
  //--------------------------------------------------------------------------
  logic [31:0] w_status;

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_full;
    w_status[1]    = w_empty;
    w_status[2]    = (state_q != S_IDLE);
    w_status[3]    = ovf_q;
    w_status[4]    = PARITY_FLAG;
    w_status[15:8] = 8'(count_q);
  end

  // Pre-edge state is sampled, so a same-cycle enqueue is not visible yet.
  always_comb begin
    load_data_d = load_data_q;
    if (i_Load_1) begin
      load_data_d = w_is_status ? w_status : 32'd0;
    end
  end

  assign o_LoadData_32 = load_data_q;

  //--------------------------------------------------------------------------
  // Sequential update
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      load_data_q <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
      load_data_q <= load_data_d;
    end
  end

  // Upper store-data bits carry no meaning for this peripheral.
  logic w_unused_store;
  assign w_unused_store = ^i_StoreData_32[31:8];

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam int          CPB   = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int   NBITS    = 11;
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam int   NBITS    = 10;
  localparam logic PAR_FLAG = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld  = 1'b0;
  logic        st  = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        o_Hit_1;
  logic [31:0] o_LoadData_32;
  logic        o_Tx_1;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_Load_1       (ld),
    .i_Store_1      (st),
    .i_Addr_32      (addr),
    .i_StoreData_32 (wdata),
    .o_Hit_1        (o_Hit_1),
    .o_LoadData_32  (o_LoadData_32),
    .o_Tx_1         (o_Tx_1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as "cycles left in frame".
  logic [7:0]  m_fifo[$];
  int          m_rem = 0;
  bit          m_ovf = 1'b0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_ld[$];
  int          cyc_cnt = 0;

  function automatic logic [31:0] status_word(input int cnt, input bit busy, input bit ovf);
    logic [31:0] w;
    logic [7:0]  c8;
    c8      = 8'(cnt);
    w       = 32'd0;
    w[0]    = (cnt == DEPTH);
    w[1]    = (cnt == 0);
    w[2]    = busy;
    w[3]    = ovf;
    w[4]    = PAR_FLAG;
    w[15:8] = c8;
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
      if (rst) begin
        m_fifo.delete();
        exp_tx.delete();
        exp_ld.delete();
        m_rem = 0;
        m_ovf = 1'b0;
      end else begin
        int pre;
        pre = m_fifo.size();
        if (ld)
          exp_ld.push_back((addr == BASE + 32'd4) ? status_word(pre, m_rem > 0, m_ovf) : 32'd0);
        if (st && addr == BASE) begin
          if (pre == DEPTH) m_ovf = 1'b1;
          else m_fifo.push_back(wdata[7:0]);
        end
        if (st && addr == BASE + 32'd4 && wdata[3]) m_ovf = 1'b0;
        if (m_rem == 0 && pre > 0) begin
          exp_tx.push_back(m_fifo.pop_front());
          m_rem = FRAME;
        end else if (m_rem > 0) begin
          m_rem--;
        end
      end
    end
  end

  // Monitor: checks load data and decodes serial frames sample by sample.
  bit              mon_active = 1'b0;
  bit              mon_bad    = 1'b0;
  bit              mon_unexp  = 1'b0;
  int              mon_k      = 0;
  logic [NBITS-1:0] mon_bits;
  logic [NBITS-1:0] mon_got;
  logic [7:0]      mon_byte;
  int              prev_start = -1;
  int              last_start = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        check("tx_idle_in_reset", {31'd0, o_Tx_1}, 32'd1);
      end else begin
        if (exp_ld.size() > 0) check("status_load", o_LoadData_32, exp_ld.pop_front());
        if (!mon_active && o_Tx_1 == 1'b0) begin
          mon_unexp = (exp_tx.size() == 0);
          mon_byte  = mon_unexp ? 8'h00 : exp_tx.pop_front();
          mon_bits  = '1;
          mon_bits[0]   = 1'b0;
          mon_bits[8:1] = mon_byte;
`ifdef MMIO_UART_TX_PARITY_EN
          mon_bits[9]   = ^mon_byte;
`endif
          mon_got    = '0;
          mon_bad    = 1'b0;
          mon_k      = 0;
          mon_active = 1'b1;
          prev_start = last_start;
          last_start = cyc_cnt;
        end
        if (mon_active) begin
          if (o_Tx_1 !== mon_bits[mon_k / CPB]) mon_bad = 1'b1;
          if (mon_k % CPB == CPB / 2) mon_got[mon_k / CPB] = o_Tx_1;
          mon_k++;
          if (mon_k == FRAME) begin
            n_cmp++;
            if (mon_bad || mon_unexp) begin
              n_bad++;
              $display("FAIL tx_frame: line bits %b, expected %b (byte %h, unexpected=%0d)",
                       mon_got, mon_bits, mon_byte, mon_unexp);
            end
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus helpers: called at a negedge, drive one cycle, return at next negedge.
  task automatic drive(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d);
    logic exp_hit;
    ld = l; st = s; addr = a; wdata = d;
    #1;
    exp_hit = (a >= BASE) && (a < BASE + 32'd8);
    check("hit", {31'd0, o_Hit_1}, {31'd0, exp_hit});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom);
  endtask

  function automatic bit quiet();
    return (m_fifo.size() == 0) && (m_rem == 0) && !mon_active && (exp_tx.size() == 0);
  endfunction

  task automatic drain();
    for (int i = 0; i < 4000 && !quiet(); i++) idle(1);
    idle(2);
    if (!quiet()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: transmitter still active, expected idle");
    end
  endtask

  task automatic random_op();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0: a = BASE;
      1: a = BASE + 32'd4;
      2: a = BASE + 32'd8 + 32'(4 * $urandom_range(0, 3));
      default: a = $urandom;
    endcase
    if (r <= 3)      drive(1'b0, 1'b1, BASE, $urandom);
    else if (r == 4) drive(1'b0, 1'b1, BASE + 32'd4, $urandom);
    else if (r <= 6) drive(1'b1, 1'b0, a, 32'd0);
    else if (r == 7) drive(1'b0, 1'b1, a, $urandom);
    else             idle(1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_loaddata", o_LoadData_32, 32'd0);
    check("reset_tx", {31'd0, o_Tx_1}, 32'd1);

    // Reset in the middle of a START bit
    drive(1'b0, 1'b1, BASE, $urandom);
    idle(2);
    #2 rst = 1'b1;
    #1 check("tx_async_reset", {31'd0, o_Tx_1}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("status_after_reset", o_LoadData_32, {27'd0, PAR_FLAG, 4'b0010});

    // Single byte, STATUS polled across the whole frame
    drive(1'b0, 1'b1, BASE, 32'h0000_00A5);
    for (int i = 0; i < FRAME + 6; i++) drive(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    drain();

    // Fill and overflow while the first byte is being sent
    drive(1'b0, 1'b1, BASE, $urandom);
    idle(1);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, BASE, $urandom);
    drive(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("fill_full_ovf", o_LoadData_32 & 32'h0000_0009, 32'h0000_0009);
    drive(1'b0, 1'b1, BASE + 32'd4, 32'h8);
    drive(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("ovf_cleared", o_LoadData_32 & 32'h0000_0008, 32'd0);
    drain();

    // Back-to-back frames
    drive(1'b0, 1'b1, BASE, 32'h55);
    drive(1'b0, 1'b1, BASE, 32'h0F);
    drain();
    check("frame_gap", 32'(last_start - prev_start), 32'(FRAME + 1));

    // Decode and read latency
    drive(1'b1, 1'b0, BASE + 32'd8, 32'd0);
    check("load_nonstatus", o_LoadData_32, 32'd0);
    ld = 1'b1; st = 1'b0; addr = BASE + 32'd4; wdata = 32'd0;
    #1 check("load_not_early", o_LoadData_32, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, BASE + 32'd12, $urandom);
    drive(1'b1, 1'b0, BASE, 32'd0);
    idle(FRAME + 4);
    check("no_stray_frame", {31'd0, mon_active}, 32'd0);

    // Parity-carrying byte (odd popcount)
    drive(1'b0, 1'b1, BASE, 32'h07);
    drain();

    // Randomised traffic
    for (int i = 0; i < 400; i++) random_op();
    drain();
    check("leftover_expected", 32'(exp_tx.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
